axis_switch_nxm: RTL and testbench

Parametrised AXI4-Stream crossbar: S_COUNT input streams are routed to M_COUNT output streams by tdest range, with per-output packet-locked arbitration and a registered output stage. Successor to the fixed 4x4 switch. Adds configurable port counts, sideband tdest per input, and per-output connectivity masks. Packets with an unroutable tdest are discarded with a per-input drop strobe. Sits between stream producers (DMA, MAC RX) and consumers (FIFOs, MAC TX).

---
 rtl/axis_switch_pkg.sv | 40 ++++
 rtl/axis_switch_arbiter.sv | 77 +++++++
 rtl/axis_switch_nxm.sv | 188 ++++++++++++++++++
 tb/tb_axis_switch_nxm.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_switch_pkg.sv
// Shared types and tdest decode helper for the N x M AXI4-Stream switch.
// Decode tables are passed zero-extended to the maximum supported sizes (16 ports, 8-bit tdest).
package axis_switch_pkg;

  typedef enum logic {ARB_RR = 1'b0, ARB_PRIO = 1'b1} arb_type_e;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FWD = 2'd2, DROP = 2'd3} in_state_e;

  localparam int MAX_PORTS = 16;
  localparam int MAX_DW    = 8;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } dec_t;

  // Lowest-index output whose range covers tdest and whose mask admits input j.
  function automatic dec_t decode_dest(input logic [MAX_DW-1:0] tdest, input int j,
                                       input int m_count, input int s_count, input int dest_width,
                                       input logic [MAX_PORTS*MAX_DW-1:0] base,
                                       input logic [MAX_PORTS*MAX_DW-1:0] top,
                                       input logic [MAX_PORTS*MAX_PORTS-1:0] connect);
    dec_t r;
    logic [MAX_DW-1:0] mask;
    logic [MAX_DW-1:0] lo;
    logic [MAX_DW-1:0] hi;
    r    = '0;
    mask = 8'hFF >> (MAX_DW - dest_width);
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      lo = 8'(base >> (i * dest_width)) & mask;
      hi = 8'(top >> (i * dest_width)) & mask;
      if (i < m_count && connect[i*s_count+j] && tdest >= lo && tdest <= hi) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_switch_arbiter.sv
// Per-output packet-locked arbiter: picks one requester while unlocked, holds the grant until release.
module axis_switch_arbiter
  import axis_switch_pkg::*;
#(
  parameter int        N        = 4,
  parameter arb_type_e ARB      = ARB_RR,
  parameter bit        LSB_HIGH = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         release_i,
  output logic [N-1:0] win_o,
  output logic [N-1:0] gnt_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          lock_q;
  logic [N-1:0]  gnt_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [N-1:0]  pick_s;
  logic [IW-1:0] pick_idx_s;
  logic          found_s;

  // Search order: rotating from ptr_q for round-robin, fixed otherwise.
  always_comb begin
    int idx;
    idx        = 0;
    pick_s     = '0;
    pick_idx_s = '0;
    found_s    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (ARB == ARB_RR) begin
        idx = (int'(ptr_q) + k) % N;
      end else if (LSB_HIGH) begin
        idx = k;
      end else begin
        idx = N - 1 - k;
      end
      if (!found_s && req_i[idx]) begin
        found_s    = 1'b1;
        pick_s     = N'(1'b1) << idx;
        pick_idx_s = IW'(idx);
      end else begin
        found_s = found_s;
      end
    end
    if (int'(pick_idx_s) == N - 1) begin
      ptr_d = '0;
    end else begin
      ptr_d = pick_idx_s + IW'(1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
      gnt_q  <= '0;
      ptr_q  <= '0;
    end else if (lock_q) begin
      if (release_i) begin
        lock_q <= 1'b0;
        gnt_q  <= '0;
      end
    end else if (found_s) begin
      lock_q <= 1'b1;
      gnt_q  <= pick_s;
      ptr_q  <= ptr_d;
    end
  end

  assign win_o = lock_q ? '0 : pick_s;
  assign gnt_o = gnt_q;

endmodule

// File: rtl/axis_switch_nxm.sv
// Parametrised AXI4-Stream crossbar: tdest-range routing, packet-locked per-output arbitration,
// one register stage per output, and discard of unroutable packets with a per-input drop strobe.
module axis_switch_nxm
  import axis_switch_pkg::*;
#(
  parameter int                               S_COUNT      = 4,
  parameter int                               M_COUNT      = 4,
  parameter int                               DATA_WIDTH   = 8,
  parameter int                               DEST_WIDTH   = 2,
  parameter logic [M_COUNT*DEST_WIDTH-1:0]    M_BASE       = {2'd3, 2'd2, 2'd1, 2'd0},
  parameter logic [M_COUNT*DEST_WIDTH-1:0]    M_TOP        = {2'd3, 2'd2, 2'd1, 2'd0},
  parameter logic [M_COUNT*S_COUNT-1:0]       M_CONNECT    = {(M_COUNT*S_COUNT){1'b1}},
  parameter string                            ARB_TYPE     = "ROUND_ROBIN",
  parameter string                            LSB_PRIORITY = "HIGH"
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_COUNT-1:0]              s_axis_tvalid,
  output logic [S_COUNT-1:0]              s_axis_tready,
  input  logic [S_COUNT-1:0]              s_axis_tlast,
  input  logic [S_COUNT*DEST_WIDTH-1:0]   s_axis_tdest,
  output logic [M_COUNT*DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_COUNT-1:0]              m_axis_tvalid,
  input  logic [M_COUNT-1:0]              m_axis_tready,
  output logic [M_COUNT-1:0]              m_axis_tlast,
  output logic [M_COUNT*DEST_WIDTH-1:0]   m_axis_tdest,
  output logic [S_COUNT-1:0]              drop_pulse
);

  localparam int        IW_M     = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
  localparam arb_type_e ARB_SEL  = (ARB_TYPE == "PRIORITY") ? ARB_PRIO : ARB_RR;
  localparam bit        LSB_HIGH = (LSB_PRIORITY == "HIGH");
  localparam logic [MAX_PORTS*MAX_DW-1:0]    BASE_X = (MAX_PORTS*MAX_DW)'(M_BASE);
  localparam logic [MAX_PORTS*MAX_DW-1:0]    TOP_X  = (MAX_PORTS*MAX_DW)'(M_TOP);
  localparam logic [MAX_PORTS*MAX_PORTS-1:0] CONN_X = (MAX_PORTS*MAX_PORTS)'(M_CONNECT);

  logic [M_COUNT-1:0][S_COUNT-1:0]    req_s;
  logic [M_COUNT-1:0][S_COUNT-1:0]    win_s;
  logic [S_COUNT-1:0]                 tready_v;
  logic [S_COUNT-1:0]                 hs_last_s;
  logic [S_COUNT-1:0][DEST_WIDTH-1:0] dest_v;
  logic [M_COUNT-1:0]                 m_valid_s;

  for (genvar j = 0; j < S_COUNT; j++) begin : g_in
    in_state_e             state_q, state_d;
    logic [IW_M-1:0]       route_q, route_d, dec_idx_s;
    logic [DEST_WIDTH-1:0] dest_q, dest_d, tdest_s;
    logic                  dec_ok_s, tvalid_s, tlast_s, tready_s, drop_q;
    logic [M_COUNT-1:0]    req_l;
    dec_t                  dec_s;

    assign tdest_s   = s_axis_tdest[j*DEST_WIDTH +: DEST_WIDTH];
    assign tvalid_s  = s_axis_tvalid[j];
    assign tlast_s   = s_axis_tlast[j];
    assign dec_s     = decode_dest(8'(tdest_s), j, M_COUNT, S_COUNT, DEST_WIDTH, BASE_X, TOP_X, CONN_X);
    assign dec_ok_s  = dec_s.valid && (int'(dec_s.idx) < M_COUNT);
    assign dec_idx_s = dec_s.idx[IW_M-1:0];

    // Ready and request generation from the latched route.
    always_comb begin
      tready_s = 1'b0;
      req_l    = '0;
      case (state_q)
        FWD:     tready_s = !m_valid_s[route_q] || m_axis_tready[route_q];
        DROP:    tready_s = 1'b1;
        default: tready_s = 1'b0;
      endcase
      if (state_q == IDLE && tvalid_s && dec_ok_s) begin
        req_l = M_COUNT'(1'b1) << dec_idx_s;
      end else if (state_q == REQ) begin
        req_l = M_COUNT'(1'b1) << route_q;
      end else begin
        req_l = '0;
      end
    end

    // IDLE requests combinationally so a win this cycle lands directly in FWD.
    always_comb begin
      state_d = state_q;
      route_d = route_q;
      dest_d  = dest_q;
      case (state_q)
        IDLE: begin
          if (tvalid_s && dec_ok_s) begin
            route_d = dec_idx_s;
            dest_d  = tdest_s;
            state_d = win_s[dec_idx_s][j] ? FWD : REQ;
          end else if (tvalid_s) begin
            state_d = DROP;
          end else begin
            state_d = IDLE;
          end
        end
        REQ:     state_d = win_s[route_q][j] ? FWD : REQ;
        FWD:     state_d = (tvalid_s && tready_s && tlast_s) ? IDLE : FWD;
        DROP:    state_d = (tvalid_s && tlast_s) ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        route_q <= '0;
        dest_q  <= '0;
        drop_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        route_q <= route_d;
        dest_q  <= dest_d;
        drop_q  <= (state_q == DROP) && tvalid_s && tlast_s;
      end
    end

    for (genvar i = 0; i < M_COUNT; i++) begin : g_req
      assign req_s[i][j] = req_l[i];
    end
    assign tready_v[j]      = tready_s;
    assign hs_last_s[j]     = tvalid_s && tready_s && tlast_s;
    assign dest_v[j]        = dest_q;
    assign s_axis_tready[j] = tready_s;
    assign drop_pulse[j]    = drop_q;
  end

  for (genvar i = 0; i < M_COUNT; i++) begin : g_out
    logic [S_COUNT-1:0]    win_l, gnt_l;
    logic                  rel_s, load_s, sel_last_s, valid_q, last_q;
    logic [DATA_WIDTH-1:0] sel_data_s, data_q;
    logic [DEST_WIDTH-1:0] sel_dest_s, dest_q;

    axis_switch_arbiter #(
      .N        (S_COUNT),
      .ARB      (ARB_SEL),
      .LSB_HIGH (LSB_HIGH)
    ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_s[i]),
      .release_i (rel_s),
      .win_o     (win_l),
      .gnt_o     (gnt_l)
    );

    assign win_s[i] = win_l;
    assign rel_s    = |(gnt_l & hs_last_s);
    assign load_s   = |(gnt_l & s_axis_tvalid & tready_v);

    // Select the beat of the locked input.
    always_comb begin
      sel_data_s = '0;
      sel_last_s = 1'b0;
      sel_dest_s = '0;
      for (int k = 0; k < S_COUNT; k++) begin
        if (gnt_l[k]) begin
          sel_data_s = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
          sel_last_s = s_axis_tlast[k];
          sel_dest_s = dest_v[k];
        end else begin
          sel_data_s = sel_data_s;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        data_q  <= '0;
        dest_q  <= '0;
      end else if (load_s) begin
        valid_q <= 1'b1;
        last_q  <= sel_last_s;
        data_q  <= sel_data_s;
        dest_q  <= sel_dest_s;
      end else if (m_axis_tready[i]) begin
        valid_q <= 1'b0;
      end
    end

    assign m_valid_s[i]                             = valid_q;
    assign m_axis_tvalid[i]                         = valid_q;
    assign m_axis_tlast[i]                          = last_q;
    assign m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign m_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH] = dest_q;
  end

endmodule

// File: tb/tb_axis_switch_nxm.sv
// Directed bench for axis_switch_nxm: table of single-packet routes plus timing/contention sequences.
module tb_axis_switch_nxm;

  localparam int S = 4, M = 4, DW = 8, TW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [S*DW-1:0] s_axis_tdata;
  logic [S-1:0]    s_axis_tvalid, s_axis_tready, s_axis_tlast, drop_pulse;
  logic [S*TW-1:0] s_axis_tdest;
  logic [M*DW-1:0] m_axis_tdata;
  logic [M-1:0]    m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [M*TW-1:0] m_axis_tdest;

  axis_switch_nxm #(
    .S_COUNT(S), .M_COUNT(M), .DATA_WIDTH(DW), .DEST_WIDTH(TW),
    .M_BASE(8'b11_10_01_00), .M_TOP(8'b11_10_01_00), .M_CONNECT(16'hDFFF),
    .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("HIGH")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdest(s_axis_tdest),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         port;
    logic [7:0] d;
    logic       l;
    logic [1:0] dst;
    int         cyc;
  } beat_t;

  typedef struct {
    int         src;
    logic [1:0] dest;
    int         n;
    logic [7:0] base;
    int         port;   // -1: packet must be dropped
  } vec_t;

  beat_t mon_q[$];
  int    drop_cnt[S];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  logic  bp_done;

  always @(posedge clk) cyc++;

  // Beats are logged mid-cycle, where inputs are stable until the next rising edge.
  always @(negedge clk) begin
    for (int p = 0; p < M; p++) begin
      if (m_axis_tvalid[p] && m_axis_tready[p]) begin
        beat_t b;
        b.port = p;
        b.d    = m_axis_tdata[p*DW +: DW];
        b.l    = m_axis_tlast[p];
        b.dst  = m_axis_tdest[p*TW +: TW];
        b.cyc  = cyc;
        mon_q.push_back(b);
      end
    end
    for (int j = 0; j < S; j++) if (drop_pulse[j]) drop_cnt[j]++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input int src, input logic [1:0] d0, input logic [1:0] d1, input int n,
                      input logic [7:0] base, output int waits);
    waits = 0;
    for (int k = 0; k < n; k++) begin
      int   budget;
      logic hs;
      budget = 0;
      hs     = 1'b0;
      s_axis_tdata[src*DW +: DW] = base + 8'(k);
      s_axis_tdest[src*TW +: TW] = (k == 0) ? d0 : d1;
      s_axis_tlast[src]          = (k == n - 1);
      s_axis_tvalid[src]         = 1'b1;
      while (!hs && budget < 200) begin
        @(negedge clk);
        hs = s_axis_tready[src];
        @(posedge clk);
        #1;
        if (!hs) begin
          waits++;
          budget++;
        end
      end
      if (!hs) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: input %0d beat %0d got no tready expected handshake", src, k);
        break;
      end
    end
    s_axis_tvalid[src] = 1'b0;
    s_axis_tlast[src]  = 1'b0;
  endtask

  task automatic check_pkt(input string name, input int off, input int port, input int n,
                           input logic [7:0] base, input logic [1:0] dst, input bit contig);
    for (int k = 0; k < n; k++) begin
      if (off + k < mon_q.size()) begin
        chk($sformatf("%s_port%0d", name, k), mon_q[off+k].port, port);
        chk($sformatf("%s_data%0d", name, k), mon_q[off+k].d, base + 8'(k));
        chk($sformatf("%s_last%0d", name, k), mon_q[off+k].l, (k == n - 1));
        chk($sformatf("%s_dest%0d", name, k), mon_q[off+k].dst, dst);
        if (contig && k > 0)
          chk($sformatf("%s_gap%0d", name, k), mon_q[off+k].cyc - mon_q[off+k-1].cyc, 1);
      end
    end
  endtask

  task automatic clear_mon();
    mon_q.delete();
    for (int j = 0; j < S; j++) drop_cnt[j] = 0;
  endtask

  vec_t vt[6];
  int   w, w0, w1, w2, w3, budget;

  initial begin
    vt[0] = '{src: 0, dest: 2'd2, n: 3, base: 8'hA1, port: 2};
    vt[1] = '{src: 1, dest: 2'd0, n: 1, base: 8'h10, port: 0};
    vt[2] = '{src: 3, dest: 2'd3, n: 2, base: 8'h30, port: 3};
    vt[3] = '{src: 1, dest: 2'd3, n: 4, base: 8'h50, port: -1};
    vt[4] = '{src: 2, dest: 2'd1, n: 2, base: 8'h60, port: 1};
    vt[5] = '{src: 0, dest: 2'd3, n: 1, base: 8'h70, port: 3};

    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdest  = '0;
    m_axis_tready = '1;
    step(2);
    chk("rst_m_tvalid", m_axis_tvalid, 4'h0);
    chk("rst_s_tready", s_axis_tready, 4'h0);
    chk("rst_drop", drop_pulse, 4'h0);
    chk("rst_m_tdata", m_axis_tdata, 32'h0);
    chk("rst_m_tlast", m_axis_tlast, 4'h0);
    chk("rst_m_tdest", m_axis_tdest, 8'h0);
    rst_n = 1'b1;
    step(2);

    // Latency: tvalid at N, first handshake at N+1, beat on output at N+2.
    s_axis_tdata[7:0] = 8'h5A;
    s_axis_tdest[1:0] = 2'd2;
    s_axis_tlast[0]   = 1'b1;
    s_axis_tvalid[0]  = 1'b1;
    #1;
    chk("lat_n_tready", s_axis_tready[0], 1'b0);
    step(1);
    chk("lat_n1_tready", s_axis_tready[0], 1'b1);
    chk("lat_n1_mvalid", m_axis_tvalid, 4'h0);
    step(1);
    chk("lat_n2_mvalid", m_axis_tvalid, 4'b0100);
    chk("lat_n2_mdata", m_axis_tdata[23:16], 8'h5A);
    chk("lat_n2_mlast", m_axis_tlast[2], 1'b1);
    chk("lat_n2_mdest", m_axis_tdest[5:4], 2'd2);
    s_axis_tvalid[0] = 1'b0;
    s_axis_tlast[0]  = 1'b0;
    step(3);

    // Round-robin contention on output 1, two rounds.
    for (int r = 0; r < 2; r++) begin
      logic [7:0] rb;
      rb = (r == 0) ? 8'h80 : 8'hC0;
      clear_mon();
      fork
        send(0, 2'd1, 2'd1, 2, rb, w0);
        send(1, 2'd1, 2'd1, 2, rb + 8'h10, w1);
        send(2, 2'd1, 2'd1, 2, rb + 8'h20, w2);
        send(3, 2'd1, 2'd1, 2, rb + 8'h30, w3);
      join
      step(4);
      chk($sformatf("rr%0d_count", r), mon_q.size(), 8);
      for (int p = 0; p < 4; p++)
        check_pkt($sformatf("rr%0d_pkt%0d", r, p), p * 2, 1, 2, rb + 8'(p * 16), 2'd1, 1'b1);
      for (int p = 1; p < 4; p++)
        if (p * 2 < mon_q.size())
          chk($sformatf("rr%0d_rearb%0d", r, p), mon_q[p*2].cyc - mon_q[p*2-1].cyc, 2);
    end

    // Table of single-packet routes, including the unroutable (masked) case.
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      send(vt[v].src, vt[v].dest, vt[v].dest, vt[v].n, vt[v].base, w);
      step(4);
      chk($sformatf("v%0d_first_wait", v), w, 1);
      if (vt[v].port < 0) begin
        chk($sformatf("v%0d_drop_outputs", v), mon_q.size(), 0);
        chk($sformatf("v%0d_drop_pulses", v), drop_cnt[vt[v].src], 1);
      end else begin
        chk($sformatf("v%0d_count", v), mon_q.size(), vt[v].n);
        check_pkt($sformatf("v%0d", v), 0, vt[v].port, vt[v].n, vt[v].base, vt[v].dest, 1'b1);
        chk($sformatf("v%0d_no_drop", v), drop_cnt[vt[v].src], 0);
      end
    end

    // Output backpressure: beat 2 is held for 5 cycles on output 0.
    clear_mon();
    bp_done = 1'b0;
    fork
      begin
        send(0, 2'd0, 2'd0, 6, 8'h20, w);
        bp_done = 1'b1;
      end
    join_none
    budget = 0;
    while (mon_q.size() < 2 && budget < 100) begin
      step(1);
      budget++;
    end
    chk("bp_reached", mon_q.size(), 2);
    m_axis_tready[0] = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step(1);
      chk($sformatf("bp_mvalid%0d", k), m_axis_tvalid[0], 1'b1);
      chk($sformatf("bp_mdata%0d", k), m_axis_tdata[7:0], 8'h22);
      chk($sformatf("bp_stready%0d", k), s_axis_tready[0], 1'b0);
    end
    m_axis_tready[0] = 1'b1;
    budget = 0;
    while (!bp_done && budget < 100) begin
      step(1);
      budget++;
    end
    chk("bp_done", bp_done, 1'b1);
    step(3);
    chk("bp_count", mon_q.size(), 6);
    check_pkt("bp", 0, 0, 6, 8'h20, 2'd0, 1'b0);

    // tdest change after the first beat is ignored.
    clear_mon();
    send(2, 2'd0, 2'd3, 3, 8'h90, w);
    step(4);
    chk("dchg_count", mon_q.size(), 3);
    check_pkt("dchg", 0, 0, 3, 8'h90, 2'd0, 1'b1);

    // Reset during the second beat abandons the packet.
    clear_mon();
    s_axis_tdata[7:0] = 8'h40;
    s_axis_tdest[1:0] = 2'd2;
    s_axis_tlast[0]   = 1'b0;
    s_axis_tvalid[0]  = 1'b1;
    step(1);
    chk("rstm_tready_before", s_axis_tready[0], 1'b1);
    step(1);
    s_axis_tdata[7:0] = 8'h41;
    rst_n = 1'b0;
    #1;
    chk("rstm_mvalid", m_axis_tvalid, 4'h0);
    chk("rstm_stready", s_axis_tready, 4'h0);
    s_axis_tvalid[0] = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("rstm_nothing_out", mon_q.size(), 0);
    send(0, 2'd2, 2'd2, 2, 8'h48, w);
    step(4);
    chk("rstm_after_wait", w, 1);
    chk("rstm_after_count", mon_q.size(), 2);
    check_pkt("rstm_after", 0, 2, 2, 8'h48, 2'd2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
